// File: rtl/bin_bcd_seq.sv
// bin_bcd_seq: sequential shift-add-3 binary to packed BCD converter with overflow error code
module bin_bcd_seq #(
  parameter int BIN_W   = 7,
  parameter int DIGITS  = 2,
  parameter int MAX_VAL = 99
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      dato_bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   dato_bcd,
  output logic                  error
);
  localparam int SW = 4*DIGITS + BIN_W;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAXV = BIN_W'(MAX_VAL);
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state, state_nx;
  logic [SW-1:0] sreg, adj, sreg_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [4*DIGITS-1:0] bcd_nx;
  logic err_nx;
  always_comb begin
    adj = sreg;
    for (int d = 0; d < DIGITS; d++)
      adj[BIN_W+4*d +: 4] = sreg[BIN_W+4*d +: 4] >= 4'd5 ? sreg[BIN_W+4*d +: 4] + 4'd3 : sreg[BIN_W+4*d +: 4];
  end
  // DONE accepts a new start exactly like IDLE so results can stream back to back
  always_comb begin
    state_nx = IDLE;
    sreg_nx  = sreg;
    cnt_nx   = cnt;
    bcd_nx   = dato_bcd;
    err_nx   = error;
    if (state == CONV) begin
      sreg_nx  = adj << 1;
      cnt_nx   = cnt + 1'b1;
      state_nx = cnt == LAST ? DONE : CONV;
      bcd_nx   = cnt == LAST ? sreg_nx[SW-1 -: 4*DIGITS] : dato_bcd;
      err_nx   = cnt == LAST ? 1'b0 : error;
    end else if (start) begin
      state_nx = dato_bin > MAXV ? DONE : CONV;
      sreg_nx  = {{(4*DIGITS){1'b0}}, dato_bin};
      cnt_nx   = '0;
      bcd_nx   = dato_bin > MAXV ? '1 : dato_bcd;
      err_nx   = dato_bin > MAXV ? 1'b1 : error;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      sreg     <= '0;
      cnt      <= '0;
      dato_bcd <= '0;
      error    <= 1'b0;
    end else begin
      state    <= state_nx;
      sreg     <= sreg_nx;
      cnt      <= cnt_nx;
      dato_bcd <= bcd_nx;
      error    <= err_nx;
    end
  end
  assign busy = state == CONV;
  assign done = state == DONE;
endmodule

// File: tb/tb_bin_bcd_seq.sv
// tb_bin_bcd_seq: scoreboard bench for the default 7-bit/2-digit and an 8-bit/3-digit converter
module tb_bin_bcd_seq;
  typedef struct {
    logic [11:0] bcd;
    logic        err;
    int          due;
  } exp_t;
  logic clk = 0, reset_n = 0;
  logic start7 = 0, start8 = 0;
  logic [6:0] dato7 = 0;
  logic [7:0] dato8 = 0;
  logic busy7, done7, err7, busy8, done8, err8;
  logic [7:0] bcd7;
  logic [11:0] bcd8;
  int cyc = 0, checks = 0, errors = 0, bcnt = 0;
  exp_t q7[$], q8[$];
  exp_t e7, e8;
  bin_bcd_seq dut7 (.clk(clk), .reset_n(reset_n), .start(start7), .dato_bin(dato7),
    .busy(busy7), .done(done7), .dato_bcd(bcd7), .error(err7));
  bin_bcd_seq #(.BIN_W(8), .DIGITS(3), .MAX_VAL(255)) dut8 (.clk(clk), .reset_n(reset_n),
    .start(start8), .dato_bin(dato8), .busy(busy8), .done(done8), .dato_bcd(bcd8), .error(err8));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy7) bcnt <= bcnt + 1;
  always @(negedge clk) begin
    if (busy7 && done7) begin
      errors++;
      $display("FAIL busy_done7 both high at cycle %0d", cyc);
    end
    if (reset_n && done7) begin
      checks++;
      if (q7.size() == 0) begin
        errors++;
        $display("FAIL done7 unexpected at cycle %0d bcd=%h err=%b", cyc, bcd7, err7);
      end else begin
        e7 = q7.pop_front();
        if ({4'h0, bcd7} !== e7.bcd || err7 !== e7.err || cyc != e7.due) begin
          errors++;
          $display("FAIL result7 got bcd=%h err=%b cycle=%0d want bcd=%h err=%b cycle=%0d",
            bcd7, err7, cyc, e7.bcd[7:0], e7.err, e7.due);
        end
      end
    end
  end
  always @(negedge clk) begin
    if (reset_n && done8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL done8 unexpected at cycle %0d bcd=%h err=%b", cyc, bcd8, err8);
      end else begin
        e8 = q8.pop_front();
        if (bcd8 !== e8.bcd || err8 !== e8.err || cyc != e8.due) begin
          errors++;
          $display("FAIL result8 got bcd=%h err=%b cycle=%0d want bcd=%h err=%b cycle=%0d",
            bcd8, err8, cyc, e8.bcd, e8.err, e8.due);
        end
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  task automatic drain;
    int n = 0;
    while ((q7.size() != 0 || q8.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(q7.size() + q8.size()), 0);
  endtask
  task automatic conv7(input logic [6:0] v, input logic [7:0] bcd, input logic e);
    start7 = 1;
    dato7 = v;
    q7.push_back('{{4'h0, bcd}, e, cyc + 1 + (e ? 0 : 7)});
    tick();
    start7 = 0;
    dato7 = 7'($urandom);
    drain();
  endtask
  task automatic conv8(input int v);
    logic [11:0] m;
    m = 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    start8 = 1;
    dato8 = 8'(v);
    q8.push_back('{m, 1'b0, cyc + 9});
    tick();
    start8 = 0;
    dato8 = 8'($urandom);
    drain();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy7), 0);
    chk("rst_done", 32'(done7), 0);
    chk("rst_bcd", 32'(bcd7), 0);
    chk("rst_err", 32'(err7), 0);
    tick();
    reset_n = 1;
    tick();
    conv7(7'd0, 8'h00, 1'b0);
    bcnt = 0;
    conv7(7'd57, 8'h57, 1'b0);
    chk("busy_cycles_57", 32'(bcnt), 7);
    bcnt = 0;
    conv7(7'd99, 8'h99, 1'b0);
    chk("busy_cycles_99", 32'(bcnt), 7);
    conv7(7'd1, 8'h01, 1'b0);
    conv7(7'd10, 8'h10, 1'b0);
    conv7(7'd45, 8'h45, 1'b0);
    conv7(7'd100, 8'hFF, 1'b1);
    conv7(7'd127, 8'hFF, 1'b1);
    conv7(7'd64, 8'h64, 1'b0);
    // start held through CONV with a new value is ignored, then accepted in DONE
    start7 = 1;
    dato7 = 7'd57;
    q7.push_back('{12'h057, 1'b0, cyc + 8});
    tick();
    dato7 = 7'd33;
    q7.push_back('{12'h033, 1'b0, cyc + 15});
    repeat (8) tick();
    start7 = 0;
    drain();
    conv7(7'd120, 8'hFF, 1'b1);
    conv7(7'd38, 8'h38, 1'b0);
    // abort in the middle of a conversion
    start7 = 1;
    dato7 = 7'd42;
    q7.push_back('{12'h042, 1'b0, cyc + 8});
    tick();
    start7 = 0;
    repeat (3) tick();
    reset_n = 0;
    q7.delete();
    #2;
    chk("abort_busy", 32'(busy7), 0);
    chk("abort_done", 32'(done7), 0);
    chk("abort_bcd", 32'(bcd7), 0);
    chk("abort_err", 32'(err7), 0);
    tick();
    reset_n = 1;
    repeat (12) tick();
    conv7(7'd42, 8'h42, 1'b0);
    for (int v = 0; v < 256; v++) conv8(v);
    chk("final_q", 32'(q7.size() + q8.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
